// File: rtl/down_timer.sv
// Loadable down-counter with prescaled tick, start/stop control and a one-cycle done pulse.
// Optional feature: define DOWN_TIMER_AUTO_RELOAD_EN to reload and keep running on expiry.
module down_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam int             PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PRESC_MAX = PW'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;
  logic             tick;

  // NOTE: the reload register is a single word, not a memory, so it is reset with the rest.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    done_d   = 1'b0;
    tick     = (state_q == RUN) && (presc_q == PRESC_MAX);

    // Stop has priority over start, even outside RUN where stop itself does nothing.
    if (stop) begin
      if (state_q == RUN) state_d = IDLE;
    end else if (start) begin
      count_d  = load_value;
      reload_d = load_value;
      presc_d  = '0;
      if (load_value != '0) begin
        state_d = RUN;
      end else begin
        state_d = EXPIRED;
        done_d  = 1'b1;
      end
    end else if (state_q == RUN) begin
      if (tick) begin
        presc_d = '0;
        if (count_q > ONE) begin
          count_d = count_q - ONE;
        end else begin
          done_d = 1'b1;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
          count_d = reload_q;
`else
          count_d = '0;
          state_d = EXPIRED;
`endif
        end
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule
